// File: rtl/bmem_link_pkg.sv
// bmem_link_pkg: shared FSM state encoding, line geometry and address helper for the bmem link bridge
package bmem_link_pkg;

    localparam int LINE_WORDS = 8;
    localparam int LINE_BYTES = 32;

    typedef enum logic [3:0] {
        IDLE,
        WR_COLLECT,
        WR_ADDR,
        WR_DATA,
        WR_WAIT,
        RD_ADDR,
        RD_DATA,
        RD_ACK,
        RD_RETURN
    } state_t;

    function automatic logic [31:0] line_align(input logic [31:0] a);
        return a & ~32'(LINE_BYTES - 1);
    endfunction

endpackage

// File: rtl/line_buffer.sv
// line_buffer: 256-bit cache-line store with 32-bit word writes, 64-bit beat writes and 64-bit beat reads
module line_buffer
    import bmem_link_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_word_en,
    input  logic [2:0]  wr_word_idx,
    input  logic [31:0] wr_word_data,
    input  logic        wr_beat_en,
    input  logic [1:0]  wr_beat_idx,
    input  logic [63:0] wr_beat_data,
    input  logic [1:0]  rd_beat_idx,
    output logic [63:0] rd_beat_data
);

    logic [LINE_WORDS-1:0][31:0] mem_q;

    // line storage; the low word of a beat lives at the even word index
    always_ff @(posedge clk) begin
        if (!rst) begin
            mem_q <= '0;
        end else begin
            if (wr_word_en)
                mem_q[wr_word_idx] <= wr_word_data;
            if (wr_beat_en) begin
                mem_q[{wr_beat_idx, 1'b0}] <= wr_beat_data[31:0];
                mem_q[{wr_beat_idx, 1'b1}] <= wr_beat_data[63:32];
            end
        end
    end

    assign rd_beat_data = {mem_q[{rd_beat_idx, 1'b1}], mem_q[{rd_beat_idx, 1'b0}]};

endmodule

// File: rtl/bmem_link_bridge.sv
// bmem_link_bridge: bridges 64-bit cache-line bursts to a 32-bit serial memory link.
// Define LINK_TIMEOUT_EN to enable the response watchdog that aborts stalled transfers and sets link_err.
module bmem_link_bridge
    import bmem_link_pkg::*;
#(
    parameter int LINE_BEATS     = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] bmem_addr,
    input  logic        bmem_read,
    input  logic        bmem_write,
    input  logic [63:0] bmem_wdata,
    output logic        bmem_ready,
    output logic [31:0] bmem_raddr,
    output logic [63:0] bmem_rdata,
    output logic        bmem_rvalid,
    output logic [31:0] address_data_bus_c_to_m,
    output logic        address_on_c_to_m,
    output logic        data_on_c_to_m,
    output logic        read_en_c_to_m,
    output logic        write_en_c_to_m,
    output logic        resp_c_to_m,
    input  logic [31:0] address_data_bus_m_to_c,
    input  logic        data_on_m_to_c,
    input  logic        resp_m_to_c,
    output logic        link_err
);

    localparam int BW = (LINE_BEATS > 1) ? $clog2(LINE_BEATS) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(LINE_BEATS - 1);
    localparam logic [2:0] LAST_WORD = 3'(LINE_WORDS - 1);

    state_t        state_q, state_d;
    logic [31:0]   addr_q, addr_d;
    logic [2:0]    word_q, word_d;
    logic [BW-1:0] beat_q, beat_d;
    logic          timeout;
    logic          wr_word_en, wr_beat_en;
    logic [BW-1:0] rd_beat;
    logic [63:0]   rd_data;

    line_buffer u_buf (
        .clk          (clk),
        .rst          (rst),
        .wr_word_en   (wr_word_en),
        .wr_word_idx  (word_q),
        .wr_word_data (address_data_bus_m_to_c),
        .wr_beat_en   (wr_beat_en),
        .wr_beat_idx  (beat_q),
        .wr_beat_data (bmem_wdata),
        .rd_beat_idx  (rd_beat),
        .rd_beat_data (rd_data)
    );

`ifdef LINK_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] wd_q;
    logic          err_q;
    logic          stalled;

    assign stalled = (state_q == WR_WAIT && !resp_m_to_c) || (state_q == RD_DATA && !data_on_m_to_c);
    assign timeout = stalled && wd_q == TW'(TIMEOUT_CYCLES - 1);
    assign link_err = err_q;

    // watchdog counts consecutive stalled wait cycles; the error flag stays set until reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            wd_q  <= '0;
            err_q <= 1'b0;
        end else begin
            wd_q  <= (stalled && !timeout) ? wd_q + TW'(1) : '0;
            err_q <= err_q | timeout;
        end
    end
`else
    assign timeout = 1'b0;
    assign link_err = (TIMEOUT_CYCLES < 0);
`endif

    // state register
    always_ff @(posedge clk) begin
        state_q <= !rst ? IDLE : state_d;
    end

    // address latch and transfer counters
    always_ff @(posedge clk) begin
        if (!rst) begin
            addr_q <= '0;
            word_q <= '0;
            beat_q <= '0;
        end else begin
            addr_q <= addr_d;
            word_q <= word_d;
            beat_q <= beat_d;
        end
    end

    // next-state, counter advance and buffer write strobes; write wins over a simultaneous read
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        word_d     = word_q;
        beat_d     = beat_q;
        wr_word_en = 1'b0;
        wr_beat_en = 1'b0;
        if (timeout) begin
            state_d = IDLE;
            word_d  = '0;
            beat_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bmem_write) begin
                        addr_d     = line_align(bmem_addr);
                        wr_beat_en = 1'b1;
                        beat_d     = BW'(1);
                        state_d    = WR_COLLECT;
                    end else if (bmem_read) begin
                        addr_d  = line_align(bmem_addr);
                        state_d = RD_ADDR;
                    end
                end
                WR_COLLECT: begin
                    if (bmem_write) begin
                        wr_beat_en = 1'b1;
                        beat_d     = (beat_q == LAST_BEAT) ? '0 : beat_q + BW'(1);
                        state_d    = (beat_q == LAST_BEAT) ? WR_ADDR : WR_COLLECT;
                    end
                end
                WR_ADDR: state_d = WR_DATA;
                WR_DATA: begin
                    word_d  = (word_q == LAST_WORD) ? '0 : word_q + 3'd1;
                    state_d = (word_q == LAST_WORD) ? WR_WAIT : WR_DATA;
                end
                WR_WAIT: state_d = resp_m_to_c ? IDLE : WR_WAIT;
                RD_ADDR: state_d = RD_DATA;
                RD_DATA: begin
                    if (data_on_m_to_c) begin
                        wr_word_en = 1'b1;
                        word_d     = (word_q == LAST_WORD) ? '0 : word_q + 3'd1;
                        state_d    = (word_q == LAST_WORD) ? RD_ACK : RD_DATA;
                    end
                end
                RD_ACK: state_d = RD_RETURN;
                RD_RETURN: begin
                    beat_d  = (beat_q == LAST_BEAT) ? '0 : beat_q + BW'(1);
                    state_d = (beat_q == LAST_BEAT) ? IDLE : RD_RETURN;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Moore outputs; undriven link fields are zero and ready is held low while reset is asserted
    always_comb begin
        bmem_ready              = rst && (state_q == IDLE || state_q == WR_COLLECT);
        address_on_c_to_m       = (state_q == WR_ADDR) || (state_q == RD_ADDR);
        write_en_c_to_m         = (state_q == WR_ADDR);
        read_en_c_to_m          = (state_q == RD_ADDR);
        data_on_c_to_m          = (state_q == WR_DATA);
        resp_c_to_m             = (state_q == RD_ACK);
        bmem_rvalid             = (state_q == RD_RETURN);
        rd_beat                 = (state_q == WR_DATA) ? BW'(word_q[2:1]) : beat_q;
        address_data_bus_c_to_m = address_on_c_to_m ? addr_q :
                                  data_on_c_to_m ? (word_q[0] ? rd_data[63:32] : rd_data[31:0]) : 32'h0;
        bmem_raddr              = bmem_rvalid ? addr_q : 32'h0;
        bmem_rdata              = bmem_rvalid ? rd_data : 64'h0;
    end

endmodule

// File: doc/bmem_link_bridge.md
BMEM_LINK_BRIDGE -- requirements
Module: bmem_link_bridge

Interface
REQ-001 SHALL have parameter LINE_BEATS, default 4, meaning 64-bit beats per 256-bit cache line.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1024, meaning link response watchdog limit.
REQ-003 SHALL have clk  input  1  the single clock; all logic on its rising edge.
REQ-004 SHALL have rst  input  1  synchronous, active-low reset (0 = reset).
REQ-005 SHALL have bmem_addr, bmem_read, bmem_write, bmem_wdata  input  32/1/1/64  cache-side request.
REQ-006 SHALL have bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid  output  1/32/64/1  cache-side response.
REQ-007 SHALL have address_data_bus_c_to_m, address_on_c_to_m, data_on_c_to_m, read_en_c_to_m, write_en_c_to_m, resp_c_to_m  output  32/1/1/1/1/1  link to memory.
REQ-008 SHALL have address_data_bus_m_to_c, data_on_m_to_c, resp_m_to_c  input  32/1/1  link from memory.
REQ-009 SHALL have link_err  output  1  sticky timeout flag.

Function
REQ-010 SHALL implement states IDLE, WR_COLLECT, WR_ADDR, WR_DATA, WR_WAIT, RD_ADDR, RD_DATA, RD_ACK, RD_RETURN.
REQ-011 SHALL drive bmem_ready=1 only in IDLE and WR_COLLECT.
REQ-012 IDLE + bmem_write: capture bmem_addr with bits[4:0] forced 0, store beat 0, go WR_COLLECT.
REQ-013 WR_COLLECT: store one beat per cycle while bmem_write=1; after beat LINE_BEATS-1 go WR_ADDR; bmem_write=0 mid-burst holds state without advancing.
REQ-014 WR_ADDR (1 cycle): address_on_c_to_m=1, write_en_c_to_m=1, bus=line address; go WR_DATA.
REQ-015 WR_DATA: 8 cycles, data_on_c_to_m=1, words in order beat0[31:0], beat0[63:32], beat1[31:0] ...; go WR_WAIT.
REQ-016 WR_WAIT: on resp_m_to_c=1 go IDLE.
REQ-017 IDLE + bmem_read (no write): capture aligned address, go RD_ADDR; RD_ADDR (1 cycle) drives address_on_c_to_m=1, read_en_c_to_m=1, bus=address.
REQ-018 RD_DATA: store each word arriving with data_on_m_to_c=1 in same order as REQ-015; after 8th word go RD_ACK.
REQ-019 RD_ACK (1 cycle): resp_c_to_m=1; go RD_RETURN.
REQ-020 RD_RETURN: LINE_BEATS consecutive cycles bmem_rvalid=1, bmem_raddr=captured address, bmem_rdata=beat k; then IDLE.
REQ-021 IDLE with bmem_read and bmem_write both 1: write SHALL win; read SHALL be discarded.
REQ-022 Requests outside IDLE/WR_COLLECT SHALL be ignored (bmem_ready=0).
REQ-023 Link outputs not being driven in a state SHALL be 0, bus 32'h0.
REQ-024 Word counter 3 bits, beat counter clog2(LINE_BEATS) bits; neither wraps inside a transaction.

Reset
REQ-025 rst=0 at any clock edge, including mid-transaction, SHALL return to IDLE, clear counters, buffer, link_err, and all outputs to 0; in-flight transaction abandoned.
REQ-026 First cycle after reset release SHALL show bmem_ready=1.

Configuration
REQ-027 With LINK_TIMEOUT_EN defined: counter in WR_WAIT and RD_DATA resets on each progress event; reaching TIMEOUT_CYCLES SHALL set link_err=1 and go IDLE (no rvalid for aborted read).
REQ-028 Without LINK_TIMEOUT_EN: no counter; waits indefinitely; link_err tied 0.

Structure
REQ-029 State enum, LINE_WORDS=8, and LINE_BYTES=32 SHALL live in shared package bmem_link_pkg.
REQ-030 Line buffer SHALL be one sub-module, line_buffer (256-bit, word-write / beat-read ports).

Verification
REQ-031 Write: beats 64'h1111_2222_3333_4444 .. 64'h4444_..._AAAA at addr 32'h1000_0024 -> link addr 32'h1000_0020, then words 32'h3333_4444, 32'h1111_2222, ... in order; IDLE after resp_m_to_c.
REQ-032 Read 32'h0000_0040, memory returns words 1..8 with gaps -> resp_c_to_m pulse once, then 4 rvalid beats 64'h2_00000001, 64'h4_00000003, ..., raddr 32'h0000_0040.
REQ-033 bmem_read and bmem_write same cycle in IDLE -> only write_en_c_to_m ever asserted; no rvalid.
REQ-034 rst=0 during RD_DATA after 3 words -> all outputs 0 next cycle, bmem_ready=1 after release, later read returns fresh data only.
REQ-035 LINK_TIMEOUT_EN, TIMEOUT_CYCLES=16, no resp after write -> link_err=1 at cycle 16, IDLE, bmem_ready=1; without macro bridge stays in WR_WAIT.
